// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single-port 512x32 SRAM built from four
// 512x8 macros. Port A (Wishbone) reads and writes with byte masks. Port B
// (waveform generator) is read-only and has priority, except that A is
// served after STARVE_LIMIT consecutive B wins while A is waiting.
// Read data comes back three cycles after the grant.
// Optional macro ARB_CONFLICT_CNT_EN enables the saturating contention counter.
module sram_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        io_wbs_clk,
    input  logic        io_wbs_rst,
    input  logic        a_req_i,
    input  logic        a_we_i,
    input  logic [3:0]  a_wmask_i,
    input  logic [8:0]  a_addr_i,
    input  logic [31:0] a_wdata_i,
    output logic        a_gnt_o,
    output logic        a_rvalid_o,
    output logic [31:0] a_rdata_o,
    input  logic        b_req_i,
    input  logic [8:0]  b_addr_i,
    output logic        b_gnt_o,
    output logic        b_rvalid_o,
    output logic [31:0] b_rdata_o,
    output logic        mem_cen_o,
    output logic        mem_gwen_o,
    output logic [31:0] mem_wen_o,
    output logic [8:0]  mem_a_o,
    output logic [31:0] mem_d_o,
    input  logic [31:0] mem_q_i,
    output logic [15:0] conflict_cnt_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic        a_gnt, b_gnt, a_win;
    logic [3:0]  starve_q, starve_d;
    logic        cen_q, cen_d, gwen_q, gwen_d;
    logic [31:0] wen_q, wen_d, d_q, d_d;
    logic [8:0]  addr_q, addr_d;
    // Owner tag pipeline: vld marks a read in flight, own=1 means port B.
    logic        rd_vld_d, rd_own_d;
    logic        rd1_vld_q, rd1_own_q, rd2_vld_q, rd2_own_q;
    logic        a_rvalid_q, b_rvalid_q;
    logic [31:0] a_rdata_q, b_rdata_q;

    // Arbitration: B has priority unless A has been starved up to the limit.
    always_comb begin
        a_win    = a_req_i & (~b_req_i | (starve_q == LIMIT));
        a_gnt    = ~io_wbs_rst & a_win;
        b_gnt    = ~io_wbs_rst & b_req_i & ~a_win;
        starve_d = (b_gnt & a_req_i) ? starve_q + 4'd1 : 4'd0;
    end

    // Next SRAM command and read-tag for the granted request.
    always_comb begin
        cen_d    = 1'b1;
        gwen_d   = 1'b1;
        wen_d    = '1;
        addr_d   = addr_q;
        d_d      = d_q;
        rd_vld_d = 1'b0;
        rd_own_d = 1'b0;
        if (a_gnt) begin
            cen_d  = 1'b0;
            addr_d = a_addr_i;
            if (a_we_i) begin
                gwen_d = 1'b0;
                d_d    = a_wdata_i;
                for (int k = 0; k < 4; k++) wen_d[8*k +: 8] = {8{~a_wmask_i[k]}};
            end else begin
                rd_vld_d = 1'b1;
            end
        end else if (b_gnt) begin
            cen_d    = 1'b0;
            addr_d   = b_addr_i;
            rd_vld_d = 1'b1;
            rd_own_d = 1'b1;
        end
    end

    // Registered SRAM interface, starvation counter and owner tag pipeline.
    always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
        if (io_wbs_rst) begin
            starve_q  <= '0;
            cen_q     <= 1'b1;
            gwen_q    <= 1'b1;
            wen_q     <= '1;
            addr_q    <= '0;
            d_q       <= '0;
            rd1_vld_q <= 1'b0;
            rd1_own_q <= 1'b0;
            rd2_vld_q <= 1'b0;
            rd2_own_q <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            cen_q     <= cen_d;
            gwen_q    <= gwen_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            d_q       <= d_d;
            rd1_vld_q <= rd_vld_d;
            rd1_own_q <= rd_own_d;
            rd2_vld_q <= rd1_vld_q;
            rd2_own_q <= rd1_own_q;
        end
    end

    // Capture macro output for the tagged owner; rvalid pulses the cycle after.
    always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
        if (io_wbs_rst) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= rd2_vld_q & ~rd2_own_q;
            b_rvalid_q <= rd2_vld_q & rd2_own_q;
            if (rd2_vld_q & ~rd2_own_q) a_rdata_q <= mem_q_i;
            if (rd2_vld_q & rd2_own_q)  b_rdata_q <= mem_q_i;
        end
    end

`ifdef ARB_CONFLICT_CNT_EN
    logic [15:0] conf_q, conf_d;

    // Saturating count of cycles with both ports requesting.
    always_comb begin
        conf_d = conf_q;
        if (a_req_i & b_req_i & (conf_q != 16'hFFFF)) conf_d = conf_q + 16'd1;
    end

    // Contention counter register.
    always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
        if (io_wbs_rst) conf_q <= '0;
        else            conf_q <= conf_d;
    end

    assign conflict_cnt_o = conf_q;
`else
    assign conflict_cnt_o = '0;
`endif

    assign a_gnt_o    = a_gnt;
    assign b_gnt_o    = b_gnt;
    assign a_rvalid_o = a_rvalid_q;
    assign b_rvalid_o = b_rvalid_q;
    assign a_rdata_o  = a_rdata_q;
    assign b_rdata_o  = b_rdata_q;
    assign mem_cen_o  = cen_q;
    assign mem_gwen_o = gwen_q;
    assign mem_wen_o  = wen_q;
    assign mem_a_o    = addr_q;
    assign mem_d_o    = d_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model (arbitration rule, memory array,
// queue of expected read returns). An SRAM macro model sits on the mem_* pins.
module tb_sram_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0;
    logic [3:0]  a_wmask = '0;
    logic [8:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0;
    logic        a_gnt_o, a_rvalid_o, b_gnt_o, b_rvalid_o;
    logic [31:0] a_rdata_o, b_rdata_o;
    logic        mem_cen_o, mem_gwen_o;
    logic [31:0] mem_wen_o, mem_d_o, mem_q_i;
    logic [8:0]  mem_a_o;
    logic [15:0] conflict_cnt_o;

    sram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .io_wbs_clk(clk), .io_wbs_rst(rst),
        .a_req_i(a_req), .a_we_i(a_we), .a_wmask_i(a_wmask), .a_addr_i(a_addr),
        .a_wdata_i(a_wdata), .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o),
        .b_req_i(b_req), .b_addr_i(b_addr), .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o),
        .b_rdata_o(b_rdata_o), .mem_cen_o(mem_cen_o), .mem_gwen_o(mem_gwen_o),
        .mem_wen_o(mem_wen_o), .mem_a_o(mem_a_o), .mem_d_o(mem_d_o), .mem_q_i(mem_q_i),
        .conflict_cnt_o(conflict_cnt_o)
    );

    always #5 clk = ~clk;

    // SRAM macro model: synchronous, active-low enables, registered output.
    logic [31:0] sram [512];
    logic [31:0] sram_q = '0;
    always @(posedge clk) begin
        if (!mem_cen_o) begin
            if (!mem_gwen_o) sram[mem_a_o] <= (sram[mem_a_o] & mem_wen_o) | (mem_d_o & ~mem_wen_o);
            else             sram_q <= sram[mem_a_o];
        end
    end
    assign mem_q_i = sram_q;

    // Reference model state.
    typedef struct { int due; bit pb; logic [31:0] data; } rd_t;
    rd_t         rq[$];
    logic [31:0] mdl_mem [512];
    int          starve, conf, cyc;
    logic        e_cen, e_gwen;
    logic [31:0] e_wen, e_d, e_ard, e_brd;
    logic [8:0]  e_a;
    bit          rand_on = 0, hold = 0;
    logic        last_a_gnt, last_b_gnt;
    int          b_rv_cnt;
    int          n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] m);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = {8{m[k]}};
        return r;
    endfunction

    function automatic logic [15:0] exp_conf();
`ifdef ARB_CONFLICT_CNT_EN
        return 16'(conf);
`else
        return 16'h0;
`endif
    endfunction

    task automatic model_reset();
        rq.delete();
        starve = 0; conf = 0;
        e_cen = 1'b1; e_gwen = 1'b1; e_wen = '1; e_a = '0; e_d = '0;
        e_ard = '0; e_brd = '0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_a_gnt", {31'b0, a_gnt_o}, 32'h0);
        chk("rst_b_gnt", {31'b0, b_gnt_o}, 32'h0);
        chk("rst_cen", {31'b0, mem_cen_o}, 32'h1);
        chk("rst_gwen", {31'b0, mem_gwen_o}, 32'h1);
        chk("rst_wen", mem_wen_o, 32'hFFFFFFFF);
        chk("rst_addr", {23'b0, mem_a_o}, 32'h0);
        chk("rst_d", mem_d_o, 32'h0);
        chk("rst_a_rv", {31'b0, a_rvalid_o}, 32'h0);
        chk("rst_b_rv", {31'b0, b_rvalid_o}, 32'h0);
        chk("rst_a_rd", a_rdata_o, 32'h0);
        chk("rst_b_rd", b_rdata_o, 32'h0);
        chk("rst_conf", {16'b0, conflict_cnt_o}, 32'h0);
    endtask

    // Called at posedge+1; asserts reset mid-cycle, holds two edges, releases at posedge+1.
    task automatic do_reset();
        #1 rst = 1'b1;
        #1 model_reset();
        chk_reset_vals();
        @(posedge clk); @(posedge clk);
        #1 chk_reset_vals();
        rst = 1'b0;
    endtask

    // One clock: check at negedge, advance the model at posedge, redrive at posedge+1.
    task automatic cycle();
        logic ea, eb, va, vb;
        @(negedge clk);
        ea = a_req && (!b_req || starve == LIMIT);
        eb = b_req && !ea;
        last_a_gnt = a_gnt_o; last_b_gnt = b_gnt_o;
        chk("a_gnt", {31'b0, a_gnt_o}, {31'b0, ea});
        chk("b_gnt", {31'b0, b_gnt_o}, {31'b0, eb});
        chk("mem_cen", {31'b0, mem_cen_o}, {31'b0, e_cen});
        chk("mem_gwen", {31'b0, mem_gwen_o}, {31'b0, e_gwen});
        chk("mem_wen", mem_wen_o, e_wen);
        chk("mem_a", {23'b0, mem_a_o}, {23'b0, e_a});
        chk("mem_d", mem_d_o, e_d);
        va = 1'b0; vb = 1'b0;
        while (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].pb) begin vb = 1'b1; e_brd = rq[0].data; end
            else          begin va = 1'b1; e_ard = rq[0].data; end
            void'(rq.pop_front());
        end
        chk("a_rvalid", {31'b0, a_rvalid_o}, {31'b0, va});
        chk("b_rvalid", {31'b0, b_rvalid_o}, {31'b0, vb});
        chk("a_rdata", a_rdata_o, e_ard);
        chk("b_rdata", b_rdata_o, e_brd);
        chk("conflict", {16'b0, conflict_cnt_o}, {16'b0, exp_conf()});
        if (b_rvalid_o) b_rv_cnt++;
        @(posedge clk);
        e_cen = 1'b1; e_gwen = 1'b1; e_wen = '1;
        if (ea) begin
            e_cen = 1'b0; e_a = a_addr;
            if (a_we) begin
                e_gwen = 1'b0; e_d = a_wdata; e_wen = ~bmask(a_wmask);
                mdl_mem[a_addr] = (mdl_mem[a_addr] & ~bmask(a_wmask)) | (a_wdata & bmask(a_wmask));
            end else begin
                rq.push_back('{cyc + 3, 1'b0, mdl_mem[a_addr]});
            end
        end else if (eb) begin
            e_cen = 1'b0; e_a = b_addr;
            rq.push_back('{cyc + 3, 1'b1, mdl_mem[b_addr]});
        end
        starve = (eb && a_req) ? starve + 1 : 0;
        if (a_req && b_req && conf < 16'hFFFF) conf++;
        cyc++;
        #1;
        if (!hold) begin
            if (ea) a_req = 1'b0;
            if (eb) b_req = 1'b0;
        end
        if (rand_on) begin
            if (!a_req && $urandom_range(0, 99) < 40) begin
                a_req = 1'b1; a_we = 1'($urandom); a_addr = 9'($urandom_range(0, 15));
                a_wdata = $urandom; a_wmask = 4'($urandom);
            end
            if (!b_req && $urandom_range(0, 99) < 50) begin
                b_req = 1'b1; b_addr = 9'($urandom_range(0, 15));
            end
        end
    endtask

    task automatic a_issue(input logic we, input logic [8:0] ad, input logic [31:0] wd,
                           input logic [3:0] m, output int waited);
        a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd; a_wmask = m;
        waited = 0;
        do begin cycle(); waited++; end while (!last_a_gnt && waited < 64);
        if (!last_a_gnt) chk("a_grant_timeout", 32'h0, 32'h1);
    endtask

    task automatic b_issue(input logic [8:0] ad);
        int w = 0;
        b_req = 1'b1; b_addr = ad;
        do begin cycle(); w++; end while (!last_b_gnt && w < 64);
        if (!last_b_gnt) chk("b_grant_timeout", 32'h0, 32'h1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int w;
        logic [19:0] pat;
        for (int i = 0; i < 512; i++) begin sram[i] = '0; mdl_mem[i] = '0; end
        cyc = 0; b_rv_cnt = 0;
        model_reset();
        // Power-up reset with both ports requesting: no grants.
        a_req = 1'b1; b_req = 1'b1;
        @(negedge clk); chk_reset_vals();
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0; a_req = 1'b0; b_req = 1'b0;

        // Full write then read-back.
        a_issue(1'b1, 9'h005, 32'hDEADBEEF, 4'b1111, w);
        chk("wr_gnt_lat", w, 1);
        a_issue(1'b0, 9'h005, 32'h0, 4'b0000, w);
        chk("rd_gnt_lat", w, 1);
        idle(4);
        chk("rd_deadbeef", a_rdata_o, 32'hDEADBEEF);

        // Masked byte write, immediately read back.
        a_issue(1'b1, 9'h005, 32'h0000AB00, 4'b0010, w);
        chk("wen_mask", mem_wen_o, 32'hFFFF00FF);
        a_issue(1'b0, 9'h005, 32'h0, 4'b0000, w);
        idle(4);
        chk("rd_masked", a_rdata_o, 32'hDEADABEF);

        // B burst over four preloaded words.
        for (int i = 0; i < 4; i++) a_issue(1'b1, 9'(i), 32'h11111111 * (i + 1), 4'hF, w);
        idle(1);
        b_rv_cnt = 0;
        for (int i = 0; i < 4; i++) b_issue(9'(i));
        idle(5);
        chk("b_burst_cnt", b_rv_cnt, 4);
        chk("b_burst_last", b_rdata_o, 32'h44444444);

        // Reset one cycle after an A read grant: read discarded, first grant right after release.
        a_issue(1'b0, 9'h001, 32'h0, 4'h0, w);
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'h002;
        do_reset();
        cycle();
        chk("gnt_after_rst", {31'b0, last_a_gnt}, 32'h1);
        idle(6);

        // Continuous contention: pattern B,B,B,B,A and conflict count.
        do_reset();
        hold = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'h003; b_req = 1'b1; b_addr = 9'h000;
        pat = '0;
        for (int i = 0; i < 10; i++) begin cycle(); pat[i] = last_a_gnt; end
`ifdef ARB_CONFLICT_CNT_EN
        chk("conf_10", {16'b0, conflict_cnt_o}, 32'd10);
`else
        chk("conf_off", {16'b0, conflict_cnt_o}, 32'd0);
`endif
        for (int i = 10; i < 20; i++) begin cycle(); pat[i] = last_a_gnt; end
        chk("starve_pat", {12'b0, pat}, 32'h00084210);
        hold = 1'b0; a_req = 1'b0; b_req = 1'b0;
        idle(5);

        // Random traffic.
        rand_on = 1'b1;
        idle(3000);
        rand_on = 1'b0; a_req = 1'b0; b_req = 1'b0;
        idle(6);
        chk("rq_drained", rq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
